servo_pwm_driver: RTL and testbench
===================================

# servo_pwm_driver

Eight-channel hobby-servo PWM generator downstream of the move sequencer. Consumes one position bit per servo (linear servos: back/forward; rotary servos: resting/rotated) and drives a 50 Hz pulse train per channel. With ramping compiled in, each channel slews between end points. A `busy` flag lets the sequencer advance on settled motion instead of a fixed one-second wait.

## Interface
- `FRAME_CYCLES`, default 1000000: PWM period in clk cycles (20 ms at 50 MHz).
- `PW_LOW`, default 50000: pulse width for position bit 0 (1 ms).
- `PW_HIGH`, default 100000: pulse width for position bit 1 (2 ms).
- `RAMP_STEP`, default 2500: maximum width change per frame; used only with ramping.
- `SETTLE_FRAMES`, default 10: frames `busy` stays high after the last width or target change.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `enable`  in  1  1 = drive pulses and advance motion; 0 = outputs low, state frozen.
- `pos`  in  8  target bits. [3:0] are linear servos 1–4; [7:4] are rotary servos t, l, b, r.
- `pwm`  out  8  registered pulse outputs, one per channel.
- `busy`  out  1  registered; high while any channel is moving or settling.
- `frame_tick`  out  1  registered; one-cycle pulse on the last cycle of each frame.

## Operation
- **Frame counter.** `cnt` is ceil(log2 FRAME_CYCLES) bits wide. It counts 0..FRAME_CYCLES-1 and wraps. It runs whenever not in reset, regardless of `enable`.
- **Frame boundary.** The boundary is the cycle with `cnt == FRAME_CYCLES-1`; `frame_tick` is high on that cycle.
- **Target sampling.** `pos` is sampled only at a boundary into `tgt_q`. Changes between boundaries are ignored.
- **Goal width.** Per channel, goal = `tgt_q[i]` ? PW_HIGH : PW_LOW.
- **Width update (ramp enabled).** At each boundary with `enable` = 1, width `w[i]` moves toward goal by at most RAMP_STEP.
  - Upward: clamp with min(w+STEP, goal).
  - Downward: clamp with max(w−STEP, goal).
  - Compare before adding so there is no overshoot and no wrap.
  - The new width applies to the frame that starts next.
- **Settle counter.** At a boundary with `enable` = 1:
  - load SETTLE_FRAMES if any `w[i]` changes or `tgt_q` changes;
  - otherwise decrement toward 0, saturating at 0.
  - `busy` = (settle != 0).
- **Pulse generation.** `pwm[i]` is high for exactly `w[i]` consecutive cycles starting at the first cycle of each frame, then low for the rest of the frame.
- **Enable low.** With `enable` = 0:
  - `pwm` is forced to 0 from the next cycle;
  - `tgt_q`, `w`, settle counter and `busy` hold;
  - `frame_tick` continues.
  
  On re-enable, pulses resume at the next frame start.
- **Reset values.** `pwm` = 0, `busy` = 0, `frame_tick` = 0, `cnt` = 0, `tgt_q` = 0, all `w` = PW_LOW, settle = 0.
- **Reset mid-operation.** Asynchronous reset clears all of the above immediately. A partial pulse is truncated.
- **Parameter legality.** Required: 0 < PW_LOW < PW_HIGH < FRAME_CYCLES and RAMP_STEP ≥ 1. Violations are not checked in RTL.

## Timing
- **Outputs.** All outputs are registered and there are no combinational paths from inputs to outputs.
- **Pulse edges.** `pwm[i]` rises on the cycle after `frame_tick` and stays high for `w[i]` cycles. After reset release, the first pulse starts on the first cycle after the release edge.
- **Latency.** `pos` must be stable on the `frame_tick` cycle. Its effect appears in the width of the next frame and in `busy` on the next cycle.
- **Simultaneous events.** If a target change and an in-progress ramp occur at the same boundary, the ramp uses the new goal immediately. A reversal mid-ramp is therefore legal and continuous.
- **Ramp duration.** With defaults, a full PW_LOW→PW_HIGH ramp takes 20 frames (400 ms). `busy` then falls 10 frames after the last step.

## Configuration
- **`SERVO_RAMP_EN` defined.** Slew-limited width update as described in Operation.
- **`SERVO_RAMP_EN` undefined.**
  - At each boundary, `w[i]` is set directly to goal; `RAMP_STEP` is unused.
  - Settle behaviour is unchanged, so `busy` is high for exactly SETTLE_FRAMES frames after a target change.

## Test plan
Bench parameters: FRAME_CYCLES=1000, PW_LOW=50, PW_HIGH=100, RAMP_STEP=10, SETTLE_FRAMES=2, ramp enabled unless noted.
- **Reset.** Hold `rst` with `pos`=0 and `enable`=1 → `pwm`=0, `busy`=0, `frame_tick`=0. After release → every `pwm` is high 50 cycles out of every 1000, and `frame_tick` pulses every 1000 cycles.
- **Ramp up.** Set `pos[0]`=1 before tick T0 → `pwm[0]` widths 60, 70, 80, 90, 100, then 100 steady. `busy` rises the cycle after T0 and falls the cycle after T6. Other channels stay at 50.
- **Reversal.** Return `pos[0]` to 0 when width is 80 → next widths 70, 60, 50. `busy` stays high continuously through the reversal.
- **Enable low.** Drop `enable` mid-ramp at width 70 for 3 frames → `pwm` is 0 and `busy` holds. After re-enable, widths continue 80, 90, 100.
- **Async reset mid-ramp.** Assert `rst` mid-pulse at width 80 → `pwm` goes low without waiting for a clock edge. After release, width is 50 and `busy`=0.
- **No-ramp build.** Without `SERVO_RAMP_EN`, set `pos`=8'hFF before T0 → all widths are 100 in the next frame. `busy` is high exactly 2 frames; with ramping it would have taken 5 frames to reach 100.

Source files
------------

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: eight-channel 50 Hz servo PWM with per-frame width slewing and a settle/busy flag.
// Define SERVO_RAMP_EN to slew widths by RAMP_STEP per frame; otherwise widths jump straight to goal.
module servo_pwm_driver #(
    parameter int unsigned FRAME_CYCLES  = 1000000,
    parameter int unsigned PW_LOW        = 50000,
    parameter int unsigned PW_HIGH       = 100000,
    parameter int unsigned RAMP_STEP     = 2500,
    parameter int unsigned SETTLE_FRAMES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] pos,
    output logic [7:0] pwm,
    output logic       busy,
    output logic       frame_tick
);
    localparam int CW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
    localparam int SW = $clog2(SETTLE_FRAMES + 2);
    localparam logic [CW-1:0] LAST   = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0] LOW    = CW'(PW_LOW);
    localparam logic [CW-1:0] HIGH   = CW'(PW_HIGH);
    localparam logic [SW-1:0] SETTLE = SW'(SETTLE_FRAMES);

    logic [CW-1:0] cnt, cnt_nxt, goal, ramp;
    logic [CW-1:0] w [8];
    logic [CW-1:0] w_nxt [8];
    logic [7:0]    tgt_q, tgt_nxt, pwm_nxt;
    logic [SW-1:0] settle, settle_nxt;
    logic          live, live_nxt, step, moved;

    // live gates pulses so a re-enable only takes effect at a frame start
    always_comb begin
        step     = enable && cnt == LAST;
        cnt_nxt  = cnt == LAST ? '0 : cnt + CW'(1);
        tgt_nxt  = step ? pos : tgt_q;
        live_nxt = enable && (live || cnt == LAST);
        moved    = step && tgt_nxt != tgt_q;
        goal     = LOW;
        ramp     = LOW;
        for (int i = 0; i < 8; i++) begin
            goal = tgt_nxt[i] ? HIGH : LOW;
`ifdef SERVO_RAMP_EN
            ramp = goal > w[i] ? (32'(goal - w[i]) > RAMP_STEP ? w[i] + CW'(RAMP_STEP) : goal)
                               : (32'(w[i] - goal) > RAMP_STEP ? w[i] - CW'(RAMP_STEP) : goal);
`else
            ramp = goal;
`endif
            w_nxt[i]   = step ? ramp : w[i];
            moved      = moved || w_nxt[i] != w[i];
            pwm_nxt[i] = live_nxt && cnt_nxt < w_nxt[i];
        end
        settle_nxt = moved ? SETTLE : (step && settle != '0) ? settle - SW'(1) : settle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            tgt_q      <= '0;
            settle     <= '0;
            live       <= 1'b1;
            pwm        <= '0;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
            for (int i = 0; i < 8; i++) w[i] <= LOW;
        end else begin
            cnt        <= cnt_nxt;
            tgt_q      <= tgt_nxt;
            settle     <= settle_nxt;
            live       <= live_nxt;
            pwm        <= pwm_nxt;
            busy       <= settle_nxt != '0;
            frame_tick <= cnt_nxt == LAST;
            for (int i = 0; i < 8; i++) w[i] <= w_nxt[i];
        end
    end
endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: frame-by-frame directed check of widths, busy and frame_tick for servo_pwm_driver.
// Expected tables cover both builds, selected by SERVO_RAMP_EN.
module tb_servo_pwm_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] pos = 8'h00;
    logic [7:0] pwm;
    logic       busy, frame_tick;
    int         n_cmp = 0, n_bad = 0;

    servo_pwm_driver #(
        .FRAME_CYCLES(1000), .PW_LOW(50), .PW_HIGH(100), .RAMP_STEP(10), .SETTLE_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pos(pos),
        .pwm(pwm), .busy(busy), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // pos/en are applied mid-frame and take effect at the boundary ending that frame;
    // w0/w7/b are this frame's expected widths on channels 0 and 7 and busy at its first cycle
    typedef struct packed {
        logic [7:0] pos;
        logic       en;
        logic [7:0] w0;
        logic [7:0] w7;
        logic       b;
    } row_t;

`ifdef SERVO_RAMP_EN
    localparam int N = 20;
    row_t tbl [N] = '{
        '{8'h01, 1'b1, 8'd50,  8'd50, 1'b0}, '{8'h01, 1'b1, 8'd60,  8'd50, 1'b1},
        '{8'h01, 1'b1, 8'd70,  8'd50, 1'b1}, '{8'h00, 1'b1, 8'd80,  8'd50, 1'b1},
        '{8'h00, 1'b1, 8'd70,  8'd50, 1'b1}, '{8'h00, 1'b1, 8'd60,  8'd50, 1'b1},
        '{8'h00, 1'b1, 8'd50,  8'd50, 1'b1}, '{8'h00, 1'b1, 8'd50,  8'd50, 1'b1},
        '{8'h01, 1'b1, 8'd50,  8'd50, 1'b0}, '{8'h01, 1'b1, 8'd60,  8'd50, 1'b1},
        '{8'h01, 1'b0, 8'd70,  8'd50, 1'b1}, '{8'h01, 1'b0, 8'd0,   8'd0,  1'b1},
        '{8'h01, 1'b0, 8'd0,   8'd0,  1'b1}, '{8'h01, 1'b1, 8'd0,   8'd0,  1'b1},
        '{8'h01, 1'b1, 8'd80,  8'd50, 1'b1}, '{8'h01, 1'b1, 8'd90,  8'd50, 1'b1},
        '{8'h01, 1'b1, 8'd100, 8'd50, 1'b1}, '{8'h01, 1'b1, 8'd100, 8'd50, 1'b1},
        '{8'h00, 1'b1, 8'd100, 8'd50, 1'b0}, '{8'h00, 1'b1, 8'd90,  8'd50, 1'b1}
    };
`else
    localparam int N = 11;
    row_t tbl [N] = '{
        '{8'hFF, 1'b1, 8'd50,  8'd50,  1'b0}, '{8'hFF, 1'b1, 8'd100, 8'd100, 1'b1},
        '{8'hFF, 1'b1, 8'd100, 8'd100, 1'b1}, '{8'h00, 1'b1, 8'd100, 8'd100, 1'b0},
        '{8'h00, 1'b1, 8'd50,  8'd50,  1'b1}, '{8'h00, 1'b1, 8'd50,  8'd50,  1'b1},
        '{8'h01, 1'b0, 8'd50,  8'd50,  1'b0}, '{8'h01, 1'b0, 8'd0,   8'd0,   1'b0},
        '{8'h01, 1'b0, 8'd0,   8'd0,   1'b0}, '{8'h01, 1'b1, 8'd0,   8'd0,   1'b0},
        '{8'h01, 1'b1, 8'd100, 8'd50,  1'b1}
    };
`endif

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (!frame_tick && n < 1100) begin
            @(negedge clk);
            n++;
        end
        if (!frame_tick) check("tick_timeout", 0, 1);
    endtask

    // Starts right after a tick cycle; ends sampled on the next tick cycle.
    task automatic run_frame(input row_t r, output int wid [8], output logic b0, output int ticks,
                             output logic tick_end);
        ticks = 0;
        b0 = 1'b0;
        for (int k = 0; k < 8; k++) wid[k] = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (c == 0) b0 = busy;
            for (int k = 0; k < 8; k++) wid[k] += int'(pwm[k]);
            ticks += int'(frame_tick);
            if (c == 500) begin
                pos = r.pos;
                enable = r.en;
            end
        end
        tick_end = frame_tick;
    endtask

    initial begin
        int   wid [8];
        logic b0, tick_end;
        int   ticks;
        repeat (3) @(negedge clk);
        check("rst_pwm", int'(pwm), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(frame_tick), 0);
        rst = 1'b0;
        wait_tick();
        for (int i = 0; i < N; i++) begin
            run_frame(tbl[i], wid, b0, ticks, tick_end);
            check($sformatf("w0[%0d]", i), wid[0], int'(tbl[i].w0));
            check($sformatf("w3[%0d]", i), wid[3], int'(tbl[i].w7));
            check($sformatf("w7[%0d]", i), wid[7], int'(tbl[i].w7));
            check($sformatf("busy[%0d]", i), int'(b0), int'(tbl[i].b));
            check($sformatf("ticks[%0d]", i), ticks, 1);
            check($sformatf("tick_end[%0d]", i), int'(tick_end), 1);
        end
        pos = 8'h00;
        repeat (40) @(negedge clk);
        check("async_pre_pwm", int'(pwm[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("async_pwm", int'(pwm), 0);
        check("async_busy", int'(busy), 0);
        check("async_tick", int'(frame_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick();
        run_frame('{8'h00, 1'b1, 8'd50, 8'd50, 1'b0}, wid, b0, ticks, tick_end);
        check("post_w0", wid[0], 50);
        check("post_w7", wid[7], 50);
        check("post_busy", int'(b0), 0);
        check("post_tick", int'(tick_end), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
